// File: rtl/imem_loader.sv
// Byte-stream boot loader: count byte, then N big-endian words written to instruction memory.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
module imem_loader #(
   parameter logic [7:0] BASE_ADDR = 8'd0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_data_i,
   output logic        byte_ready_o,
   input  logic        restart_i,
   output logic        imem_we_o,
   output logic [7:0]  imem_addr_o,
   output logic [31:0] imem_data_o,
   output logic        start_o,
   output logic        busy_o,
   output logic        err_o
);

   localparam int unsigned WCNT_W = 9;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WORD  = 3'd1;
   localparam logic [2:0] S_WRITE = 3'd2;
`ifdef LOADER_CHECKSUM_EN
   localparam logic [2:0] S_CHECK = 3'd3;
`endif
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_ERROR = 3'd5;

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic              w_xfer;
   logic              w_last_byte;
   logic [1:0]        r_bcnt;
   logic [WCNT_W-1:0] r_wcnt;
   logic [7:0]        r_idx;
   logic [23:0]       r_word;

   assign w_xfer      = byte_valid_i & byte_ready_o;
   assign w_last_byte = (r_state == S_WORD) && w_xfer && (r_bcnt == 2'd3);

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] r_csum;
   logic       w_csum_ok;
   assign w_csum_ok = (byte_data_i == r_csum);
`endif

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_xfer) w_next = S_WORD;
         S_WORD:  if (w_last_byte) w_next = S_WRITE;
         S_WRITE: begin
            if (r_wcnt == WCNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
               w_next = S_CHECK;
`else
               w_next = S_DONE;
`endif
            end else begin
               w_next = S_WORD;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: if (w_xfer) w_next = w_csum_ok ? S_DONE : S_ERROR;
`endif
         S_DONE:  if (restart_i) w_next = S_IDLE;
         S_ERROR: if (restart_i) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Registered status outputs decoded from the state being entered
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         byte_ready_o <= 1'b1;
         busy_o       <= 1'b0;
         start_o      <= 1'b0;
         imem_we_o    <= 1'b0;
      end else begin
         byte_ready_o <= (w_next == S_IDLE) || (w_next == S_WORD)
`ifdef LOADER_CHECKSUM_EN
                         || (w_next == S_CHECK)
`endif
                         ;
         busy_o       <= (w_next != S_IDLE) && (w_next != S_DONE) && (w_next != S_ERROR);
         start_o      <= (w_next == S_DONE);
         imem_we_o    <= (w_next == S_WRITE);
      end
   end

`ifdef LOADER_CHECKSUM_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) err_o <= 1'b0;
      else       err_o <= (w_next == S_ERROR);
   end
`else
   assign err_o = 1'b0;
`endif

   // Word assembly, index and remaining-word bookkeeping
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_bcnt      <= 2'd0;
         r_wcnt      <= '0;
         r_idx       <= 8'd0;
         r_word      <= 24'd0;
         imem_addr_o <= 8'd0;
         imem_data_o <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
         r_csum      <= 8'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_wcnt <= (byte_data_i == 8'd0) ? WCNT_W'(256) : WCNT_W'(byte_data_i);
                  r_idx  <= BASE_ADDR;
                  r_bcnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= 8'd0;
`endif
               end
            end
            S_WORD: begin
               if (w_xfer) begin
                  r_word <= {r_word[15:0], byte_data_i};
                  r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ byte_data_i;
`endif
               end
               if (w_last_byte) begin
                  imem_addr_o <= r_idx;
                  imem_data_o <= {r_word, byte_data_i};
               end
            end
            S_WRITE: begin
               r_idx  <= r_idx + 8'd1;
               r_wcnt <= r_wcnt - WCNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (BASE_ADDR 0 and 255) share stimulus; writes are
// checked against an expected-write scoreboard built from the loaded word list.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid = 1'b0;
   logic [7:0]  data = 8'd0;
   logic        restart = 1'b0;

   logic        rdy0, we0, start0, busy0, err0;
   logic [7:0]  addr0;
   logic [31:0] wd0;
   logic        rdy1, we1, start1, busy1, err1;
   logic [7:0]  addr1;
   logic [31:0] wd1;

   int n_total = 0;
   int n_pass  = 0;

   logic [39:0] q0[$];
   logic [39:0] q1[$];
   logic [31:0] words [256];

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(8'd0)) dut0 (
      .clk_i(clk), .rst_i(rst), .byte_valid_i(valid), .byte_data_i(data),
      .byte_ready_o(rdy0), .restart_i(restart), .imem_we_o(we0), .imem_addr_o(addr0),
      .imem_data_o(wd0), .start_o(start0), .busy_o(busy0), .err_o(err0));

   imem_loader #(.BASE_ADDR(8'd255)) dut1 (
      .clk_i(clk), .rst_i(rst), .byte_valid_i(valid), .byte_data_i(data),
      .byte_ready_o(rdy1), .restart_i(restart), .imem_we_o(we1), .imem_addr_o(addr1),
      .imem_data_o(wd1), .start_o(start1), .busy_o(busy1), .err_o(err1));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // XOR of every payload byte of the first n words
   function automatic logic [7:0] model_xor(input int n);
      logic [7:0] x = 8'd0;
      for (int k = 0; k < n; k++)
         x = x ^ words[k][31:24] ^ words[k][23:16] ^ words[k][15:8] ^ words[k][7:0];
      return x;
   endfunction

   // Per-cycle scoreboard: every strobe must match the next expected write
   always @(negedge clk) begin
      if (!rst) begin
         if (we0) begin
            if (q0.size() == 0) chk("stray_we0", 64'(we0), 64'd0);
            else chk("write0", 64'({addr0, wd0}), 64'(q0.pop_front()));
            chk("ready_in_write0", 64'(rdy0), 64'd0);
            chk("busy_in_write0", 64'(busy0), 64'd1);
         end
         if (we1) begin
            if (q1.size() == 0) chk("stray_we1", 64'(we1), 64'd0);
            else chk("write1", 64'({addr1, wd1}), 64'(q1.pop_front()));
         end
         if (start0) begin
            chk("done_ready0", 64'(rdy0), 64'd0);
            chk("done_busy0", 64'(busy0), 64'd0);
            chk("done_err0", 64'(err0), 64'd0);
         end
      end
   end

   task automatic idle_cycle();
      valid = 1'b0;
      data  = 8'($urandom);
      @(negedge clk);
   endtask

   // Offer a byte until both loaders take it; returns at the negedge after the transfer
   task automatic send_byte(input logic [7:0] b);
      int t = 0;
      bit ok = 1'b0;
      valid = 1'b1;
      data  = b;
      while (!ok && t < 64) begin
         ok = rdy0 && rdy1;
         @(posedge clk);
         @(negedge clk);
         t++;
      end
      if (!ok) chk("byte_accept_timeout", 64'(rdy0), 64'd1);
      valid = 1'b0;
   endtask

   // cs_mode: -1 correct checksum, -2 random wrong checksum, otherwise literal byte
   task automatic do_load(input int n, input int gap_at, input bit push_model, input int cs_mode);
      int bi = 0;
      bit exp_start;
      if (push_model) begin
         for (int k = 0; k < n; k++) begin
            q0.push_back({8'(k), words[k]});
            q1.push_back({8'(255 + k), words[k]});
         end
      end
      send_byte(8'(n));
      chk("busy_after_count", 64'(busy0), 64'd1);
      chk("ready_after_count", 64'(rdy0), 64'd1);
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < 4; j++) begin
            if (bi == gap_at) begin
               for (int g = 0; g < 10; g++) begin
                  idle_cycle();
                  chk("gap_no_we", 64'(we0), 64'd0);
               end
            end else if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) idle_cycle();
            end
            restart = (k == n - 1 && j == 3) ? 1'b0 : 1'($urandom_range(0, 1));
            send_byte(words[k][31 - 8*j -: 8]);
            bi++;
         end
      end
      restart = 1'b0;
`ifdef LOADER_CHECKSUM_EN
      begin
         logic [7:0] x = model_xor(n);
         logic [7:0] cs;
         if (cs_mode == -1)      cs = x;
         else if (cs_mode == -2) cs = x ^ 8'($urandom_range(1, 255));
         else                    cs = 8'(cs_mode);
         exp_start = (cs == x);
         send_byte(cs);
         chk("cs_start0", 64'(start0), 64'(exp_start));
         chk("cs_start1", 64'(start1), 64'(exp_start));
         chk("cs_err0", 64'(err0), 64'(!exp_start));
         chk("cs_busy0", 64'(busy0), 64'd0);
      end
`else
      exp_start = (cs_mode != -3);
      chk("we_latency", 64'(we0), 64'd1);
      chk("start_not_yet", 64'(start0), 64'd0);
      @(negedge clk);
      chk("start0", 64'(start0), 64'(exp_start));
      chk("start1", 64'(start1), 64'(exp_start));
      chk("err0", 64'(err0), 64'd0);
      chk("busy_done0", 64'(busy0), 64'd0);
`endif
      chk("all_writes0", 64'(q0.size()), 64'd0);
      chk("all_writes1", 64'(q1.size()), 64'd0);
      valid = 1'b1;
      data  = 8'($urandom);
      repeat (3) @(negedge clk);
      valid = 1'b0;
      chk("end_ready0", 64'(rdy0), 64'd0);
      chk("end_start_held", 64'(start0), 64'(exp_start));
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("restart_ready0", 64'(rdy0), 64'd1);
      chk("restart_start0", 64'(start0), 64'd0);
      chk("restart_err0", 64'(err0), 64'd0);
      chk("restart_busy0", 64'(busy0), 64'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_we0", 64'(we0), 64'd0);
      chk("rst_addr0", 64'(addr0), 64'd0);
      chk("rst_data0", 64'(wd0), 64'd0);
      chk("rst_start0", 64'(start0), 64'd0);
      chk("rst_busy0", 64'(busy0), 64'd0);
      chk("rst_err0", 64'(err0), 64'd0);
      chk("rst_ready0", 64'(rdy0), 64'd1);
      chk("rst_addr1", 64'(addr1), 64'd0);
      chk("rst_we1", 64'(we1), 64'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check_reset_outputs();
      #1 rst = 1'b0;
      @(negedge clk);

      // Directed two-word load with literal expectations
      words[0] = 32'h20080005;
      words[1] = 32'h01095020;
      q0.push_back({8'h00, 32'h20080005});
      q0.push_back({8'h01, 32'h01095020});
      q1.push_back({8'hFF, 32'h20080005});
      q1.push_back({8'h00, 32'h01095020});
      do_load(2, -1, 1'b0, -1);

      // Ten-cycle stall after two payload bytes
      words[0] = $urandom;
      do_load(1, 2, 1'b1, -1);

`ifdef LOADER_CHECKSUM_EN
      words[0] = 32'h20080005;
      chk("model_xor_pin", 64'(model_xor(1)), 64'h2D);
      do_load(1, -1, 1'b1, 8'h2D);
      do_load(1, -1, 1'b1, 8'h2C);
`endif

      // Reset after three payload bytes, then a full reload
      words[0] = $urandom;
      send_byte(8'd1);
      for (int j = 0; j < 3; j++) send_byte(words[0][31 - 8*j -: 8]);
      #1 rst = 1'b1;
      #1 check_reset_outputs();
      @(negedge clk);
      #1 rst = 1'b0;
      q0.delete();
      q1.delete();
      words[0] = $urandom;
      words[1] = $urandom;
      do_load(2, -1, 1'b1, -1);

      // Reset landing in the write-strobe cycle
      words[0] = $urandom;
      send_byte(8'd2);
      for (int j = 0; j < 3; j++) send_byte(words[0][31 - 8*j -: 8]);
      valid = 1'b1;
      data  = words[0][7:0];
      @(posedge clk);
      #1 rst = 1'b1;
      valid = 1'b0;
      #1 chk("rst_drops_we0", 64'(we0), 64'd0);
      chk("rst_drops_we1", 64'(we1), 64'd0);
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) words[k] = $urandom;
      do_load(3, -1, 1'b1, -1);

      // Count byte zero means 256 words
      for (int k = 0; k < 256; k++) words[k] = $urandom;
      do_load(256, -1, 1'b1, -1);

      // Randomized loads
      for (int it = 0; it < 8; it++) begin
         int n = $urandom_range(1, 5);
         for (int k = 0; k < n; k++) words[k] = $urandom;
         do_load(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4*n - 1)) : -1,
                 1'b1, ($urandom_range(0, 2) == 0) ? -2 : -1);
      end

      chk("final_q0_empty", 64'(q0.size()), 64'd0);
      chk("final_q1_empty", 64'(q1.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have one parameter: BASE_ADDR, default 0, the 8-bit word index at which the first loaded word is written.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset; asynchronous and active-high.
REQ-004 byte_valid_i  input  1  upstream byte offered.
REQ-005 byte_data_i  input  8  upstream byte.
REQ-006 byte_ready_o  output  1  loader accepts a byte this cycle.
REQ-007 restart_i  input  1  return from DONE or ERROR to IDLE.
REQ-008 imem_we_o  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 imem_addr_o  output  8  word index being written.
REQ-010 imem_data_o  output  32  instruction word being written.
REQ-011 start_o  output  1  CPU start; high only in DONE.
REQ-012 busy_o  output  1  high in every state except IDLE, DONE and ERROR.
REQ-013 err_o  output  1  high only in ERROR.

Function
REQ-014 A byte transfer SHALL occur only on a rising edge where byte_valid_i and byte_ready_o are both 1.
REQ-015 The states SHALL be IDLE, WORD, WRITE, CHECK, DONE and ERROR.
REQ-016 byte_ready_o SHALL be 1 in IDLE, WORD and CHECK, and 0 in WRITE, DONE and ERROR.
REQ-017 IDLE: the first transferred byte SHALL be the word count N, where 0 means 256; the loader SHALL then go to WORD with word index = BASE_ADDR.
REQ-018 WORD: bytes SHALL be assembled MSB first; the 4th byte SHALL move the state to WRITE.
REQ-019 WRITE lasts exactly one cycle: imem_we_o = 1, imem_addr_o = current index, imem_data_o = assembled word.
REQ-020 Latency: a 4th byte accepted at edge k SHALL give the write strobe in the cycle after edge k.
REQ-021 After WRITE the index SHALL increment modulo 256 (255 wraps to 0) and the remaining-word count SHALL decrement.
REQ-022 After WRITE: if words remain, the state SHALL return to WORD; otherwise it SHALL go to CHECK when LOADER_CHECKSUM_EN is defined, or to DONE when it is not.
REQ-023 DONE SHALL hold start_o = 1 and ignore byte_valid_i.
REQ-024 restart_i = 1 in DONE or ERROR SHALL move the state to IDLE on the next edge; restart_i SHALL be ignored in all other states.
REQ-025 Outside WRITE, imem_we_o SHALL be 0; imem_addr_o and imem_data_o SHALL hold their last values.
REQ-026 byte_valid_i low mid-word SHALL stall assembly indefinitely with no timeout and no loss of partial bytes.

Reset
REQ-027 When rst_i is high the loader SHALL force state IDLE, imem_we_o = 0, imem_addr_o = 0, imem_data_o = 0, start_o = 0, busy_o = 0 and err_o = 0, with byte count, word count and checksum cleared.
REQ-028 Reset asserted mid-load SHALL abort immediately; any write strobe active in that cycle SHALL be dropped and no partial word SHALL be written afterwards.

Configuration
REQ-029 When the macro LOADER_CHECKSUM_EN is defined, the loader SHALL keep a running XOR of all payload bytes (count byte excluded) and accept one checksum byte in CHECK.
REQ-030 In CHECK, a checksum byte equal to the running XOR SHALL move the state to DONE; any other value SHALL move it to ERROR, with start_o held at 0.
REQ-031 When LOADER_CHECKSUM_EN is not defined, there SHALL be no CHECK state, no checksum logic and no checksum byte; err_o SHALL be tied to 0.

Verification
REQ-032 Bytes 02, 20,08,00,05, 01,09,50,20 with no checksum build -> writes 0x20080005 at index 0, then 0x01095020 at index 1; start_o = 1 two cycles after the last byte.
REQ-033 BASE_ADDR = 255 and N = 2 -> writes go to indices 255 then 0.
REQ-034 Checksum build, payload 20,08,00,05, checksum 2D -> reaches DONE; checksum 2C -> err_o = 1 and start_o stays 0.
REQ-035 byte_valid_i held low for 10 cycles after 2 payload bytes -> no write strobe during the gap; the final word is correct.
REQ-036 rst_i pulsed after 3 payload bytes, then a full reload -> no stray write strobe; start_o is correct.
REQ-037 Count byte 00 -> exactly 256 write strobes, indices wrap correctly, then DONE; restart_i in DONE -> back to IDLE.
